// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: state encoding, access-size codes and big-endian lane helper
package mem_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    // bit position of the byte at the given offset in a big-endian word: (3-offset)*8
    function automatic logic [4:0] byte_lane_sel(input logic [1:0] offset);
        return {~offset, 3'b000};
    endfunction
endpackage

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: CPU request side and memory port of the access controller
interface mem_access_ctrl_if;
    logic        i_req;
    logic        i_we;
    logic [1:0]  i_size;
    logic        i_sign;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic        o_ready;
    logic        o_done;
    logic        o_err;
    logic [31:0] o_rdata;
    logic        o_MemRead;
    logic        o_MemWrite;
    logic [31:0] o_addr;
    logic [31:0] o_WriteData;
    logic [31:0] i_MemData;
    modport slave (
        input  i_req, i_we, i_size, i_sign, i_addr, i_wdata, i_MemData,
        output o_ready, o_done, o_err, o_rdata, o_MemRead, o_MemWrite, o_addr, o_WriteData
    );
    modport master (
        output i_req, i_we, i_size, i_sign, i_addr, i_wdata, i_MemData,
        input  o_ready, o_done, o_err, o_rdata, o_MemRead, o_MemWrite, o_addr, o_WriteData
    );
endinterface

// File: rtl/byte_lane_unit.sv
// byte_lane_unit: big-endian sub-word merge into a word and extract/extend out of a word
module byte_lane_unit import mem_ctrl_pkg::*; (
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        sign,
    input  logic [31:0] wdata,
    output logic [31:0] merged,
    output logic [31:0] extracted
);
    logic [4:0]  sh;
    logic [31:0] lane_mask;
    logic [31:0] lane;
    logic [31:0] fill;
    // the shift is set by the last byte of the access, which is the least significant one
    always_comb begin
        sh = byte_lane_sel(size == SIZE_BYTE ? offset : size == SIZE_HALF ? {offset[1], 1'b1} : 2'b11);
        lane_mask = size == SIZE_BYTE ? 32'h0000_00FF : size == SIZE_HALF ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        lane = (word >> sh) & lane_mask;
        fill = (sign && (size == SIZE_BYTE ? lane[7] : lane[15])) ? ~lane_mask : 32'h0;
        merged = (word & ~(lane_mask << sh)) | ((wdata & lane_mask) << sh);
        extracted = size == SIZE_WORD ? word : lane | fill;
    end
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: byte/half/word load-store initiator for a word-wide big-endian memory
// Sub-word stores run as read-modify-write; bad requests finish in one cycle with o_err.
module mem_access_ctrl import mem_ctrl_pkg::*; #(
    parameter int MEM_BYTES = 256
) (
    input logic i_clk,
    input logic i_rst,
    mem_access_ctrl_if.slave bus
);
    state_t      state_q, state_d;
    logic        we_q, sign_q, err_q, req_err;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q, rd_word_q, rdata_q, merged, extracted;
    always_comb begin
        req_err = bus.i_size == 2'b11
               || (bus.i_size == SIZE_HALF && bus.i_addr[0])
               || (bus.i_size == SIZE_WORD && bus.i_addr[1:0] != 2'b00)
               || bus.i_addr >= 32'(MEM_BYTES);
        state_d = state_q == IDLE ? (bus.i_req ? (req_err ? DONE : (bus.i_we && bus.i_size == SIZE_WORD) ? WR : RD) : IDLE)
                : state_q == RD   ? (we_q ? WR : DONE)
                : state_q == WR   ? DONE
                : IDLE;
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end
    // the lane unit extracts from live memory data in RD and merges into the latched word in WR
    byte_lane_unit u_lane (
        .word      (state_q == RD ? bus.i_MemData : rd_word_q),
        .offset    (addr_q[1:0]),
        .size      (size_q),
        .sign      (sign_q),
        .wdata     (wdata_q),
        .merged    (merged),
        .extracted (extracted)
    );
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            we_q      <= 1'b0;
            sign_q    <= 1'b0;
            err_q     <= 1'b0;
            size_q    <= 2'b00;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            rd_word_q <= 32'h0;
            rdata_q   <= 32'h0;
        end else begin
            if (state_q == IDLE && bus.i_req) begin
                we_q    <= bus.i_we;
                sign_q  <= bus.i_sign;
                err_q   <= req_err;
                size_q  <= bus.i_size;
                addr_q  <= bus.i_addr;
                wdata_q <= bus.i_wdata;
            end
            if (state_q == RD) begin
                rd_word_q <= bus.i_MemData;
                if (!we_q) rdata_q <= extracted;
            end
        end
    end
    assign bus.o_ready     = state_q == IDLE;
    assign bus.o_done      = state_q == DONE;
    assign bus.o_err       = state_q == DONE && err_q;
    assign bus.o_rdata     = rdata_q;
    assign bus.o_MemRead   = state_q == RD;
    assign bus.o_MemWrite  = state_q == WR && !i_rst;
    assign bus.o_addr      = (state_q == RD || state_q == WR) ? {addr_q[31:2], 2'b00} : 32'h0;
    assign bus.o_WriteData = state_q == WR ? merged : 32'h0;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: randomized load/store traffic against a byte-array memory model
// Per-cycle expectations come from a request-level schedule built by the driver.
module tb_mem_access_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_access_ctrl_if bus();
    mem_access_ctrl #(.MEM_BYTES(256)) dut (.i_clk(clk), .i_rst(rst), .bus(bus.slave));

    typedef struct {
        logic        ready, done, err, mread, mwrite;
        logic [31:0] addr, wdata, rdata;
    } rec_t;
    typedef struct {
        string       nm;
        int          sel;
        logic [31:0] e;
    } lit_t;

    rec_t        exp_q[$];
    lit_t        lit_q[$];
    rec_t        r;
    int          lit_idx = 0;
    logic [7:0]  refm[256];
    logic [31:0] env_mem[64];
    logic        mem_init = 1'b1;
    logic        chk_en = 1'b0;
    logic [31:0] cur_rdata = 32'h0;
    logic [31:0] lv;
    int          checks = 0;
    int          failures = 0;

    assign bus.i_MemData = env_mem[bus.o_addr[7:2]];

    always @(posedge clk) begin
        if (mem_init)
            for (int i = 0; i < 64; i++)
                env_mem[i] <= {refm[4*i], refm[4*i+1], refm[4*i+2], refm[4*i+3]};
        else if (bus.o_MemWrite)
            env_mem[bus.o_addr[7:2]] <= bus.o_WriteData;
    end

    function automatic rec_t mk(input logic rd, input logic wr, input logic dn, input logic er,
                                input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rv);
        rec_t t;
        t.ready = 1'b0; t.mread = rd; t.mwrite = wr; t.done = dn; t.err = er;
        t.addr = a; t.wdata = wd; t.rdata = rv;
        return t;
    endfunction

    // single compare process: scheduled per-cycle expectations plus queued literal checks
    always @(negedge clk) begin
        if (chk_en) begin
            if (exp_q.size() > 0) r = exp_q[0];
            else begin
                r.ready = 1'b1; r.done = 1'b0; r.err = 1'b0; r.mread = 1'b0; r.mwrite = 1'b0;
                r.addr = 32'h0; r.wdata = 32'h0; r.rdata = cur_rdata;
            end
            checks += 7;
            if (bus.o_ready !== r.ready)     begin failures++; $display("FAIL ready t=%0t got=%b want=%b", $time, bus.o_ready, r.ready); end
            if (bus.o_done !== r.done)       begin failures++; $display("FAIL done t=%0t got=%b want=%b", $time, bus.o_done, r.done); end
            if (bus.o_err !== r.err)         begin failures++; $display("FAIL err t=%0t got=%b want=%b", $time, bus.o_err, r.err); end
            if (bus.o_MemRead !== r.mread)   begin failures++; $display("FAIL memread t=%0t got=%b want=%b", $time, bus.o_MemRead, r.mread); end
            if (bus.o_MemWrite !== r.mwrite) begin failures++; $display("FAIL memwrite t=%0t got=%b want=%b", $time, bus.o_MemWrite, r.mwrite); end
            if (bus.o_addr !== r.addr)       begin failures++; $display("FAIL addr t=%0t got=%h want=%h", $time, bus.o_addr, r.addr); end
            if (bus.o_rdata !== r.rdata)     begin failures++; $display("FAIL rdata t=%0t got=%h want=%h", $time, bus.o_rdata, r.rdata); end
            if (r.mwrite) begin
                checks++;
                if (bus.o_WriteData !== r.wdata) begin failures++; $display("FAIL writedata t=%0t got=%h want=%h", $time, bus.o_WriteData, r.wdata); end
            end
        end
        while (lit_idx < lit_q.size()) begin
            case (lit_q[lit_idx].sel)
                0:       lv = bus.o_rdata;
                1:       lv = env_mem[32];
                2:       lv = {31'h0, bus.o_ready};
                3:       lv = {28'h0, bus.o_done, bus.o_err, bus.o_MemRead, bus.o_MemWrite};
                4:       lv = bus.o_addr;
                default: lv = bus.o_WriteData;
            endcase
            checks++;
            if (lv !== lit_q[lit_idx].e) begin
                failures++;
                $display("FAIL %s t=%0t got=%h want=%h", lit_q[lit_idx].nm, $time, lv, lit_q[lit_idx].e);
            end
            lit_idx++;
        end
    end

    task automatic lit(input string nm, input int sel, input logic [31:0] e);
        lit_t t;
        t.nm = nm; t.sel = sel; t.e = e;
        lit_q.push_back(t);
    endtask

    task automatic junk();
        bus.i_req   = 1'($urandom_range(0, 1));
        bus.i_we    = 1'($urandom_range(0, 1));
        bus.i_size  = 2'($urandom_range(0, 3));
        bus.i_sign  = 1'($urandom_range(0, 1));
        bus.i_addr  = $urandom;
        bus.i_wdata = $urandom;
    endtask

    // one request: drive, build the expected schedule from byte-level rules, walk it
    task automatic do_op(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata, input int rst_cyc);
        logic [7:0]  b[4];
        logic [31:0] aw, v, nw;
        rec_t        t;
        int          n, off, base;
        logic        err, aborted;
        aborted = 1'b0;
        n = 1 << size;
        off = int'(addr[1:0]);
        aw = {addr[31:2], 2'b00};
        base = int'(aw[7:0]);
        err = size == 2'd3 || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0) || addr >= 32'd256;
        @(posedge clk);
        #2;
        bus.i_req = 1'b1; bus.i_we = we; bus.i_size = size; bus.i_sign = sgn;
        bus.i_addr = addr; bus.i_wdata = wdata;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) b[k] = refm[base + k];
        if (err) exp_q.push_back(mk(0, 0, 1, 1, 0, 0, cur_rdata));
        else if (!we) begin
            v = 32'h0;
            for (int i = 0; i < n; i++) v = (v << 8) | 32'(b[off + i]);
            if (n < 4 && sgn && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
            exp_q.push_back(mk(1, 0, 0, 0, aw, 0, cur_rdata));
            exp_q.push_back(mk(0, 0, 1, 0, 0, 0, v));
            cur_rdata = v;
        end else begin
            for (int i = 0; i < n; i++) b[off + i] = 8'(wdata >> (8*(n-1-i)));
            nw = {b[0], b[1], b[2], b[3]};
            if (size != 2'd2) exp_q.push_back(mk(1, 0, 0, 0, aw, 0, cur_rdata));
            exp_q.push_back(mk(0, 1, 0, 0, aw, nw, cur_rdata));
            exp_q.push_back(mk(0, 0, 1, 0, 0, 0, cur_rdata));
        end
        junk();
        for (int c = 1; c <= 3; c++) begin
            if (exp_q.size() == 0) break;
            if (c == rst_cyc) begin
                t = exp_q[0];
                t.mwrite = 1'b0;
                exp_q.delete();
                exp_q.push_back(t);
                rst = 1'b1;
            end
            @(posedge clk);
            #1;
            void'(exp_q.pop_front());
            if (c == rst_cyc) begin
                rst = 1'b0;
                cur_rdata = 32'h0;
                aborted = 1'b1;
                break;
            end
            junk();
        end
        bus.i_req = 1'b0;
        if (!err && we && !aborted)
            for (int k = 0; k < 4; k++) refm[base + k] = b[k];
    endtask

    initial begin
        bus.i_req = 1'b0; bus.i_we = 1'b0; bus.i_size = 2'b00; bus.i_sign = 1'b0;
        bus.i_addr = 32'h0; bus.i_wdata = 32'h0;
        for (int i = 0; i < 256; i++) refm[i] = 8'($urandom);
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        lit("rst_ready", 2, 32'h1);
        lit("rst_flags", 3, 32'h0);
        lit("rst_rdata", 0, 32'h0);
        lit("rst_addr", 4, 32'h0);
        lit("rst_wdata", 5, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mem_init = 1'b0;

        do_op(1, 2'd2, 0, 32'h80, 32'hDEADBEEF, 0);
        lit("sw_mem", 1, 32'hDEADBEEF);
        do_op(0, 2'd2, 0, 32'h80, 32'h0, 0);
        lit("lw_rdata", 0, 32'hDEADBEEF);
        do_op(0, 2'd0, 1, 32'h83, 32'h0, 0);
        lit("lb_sign", 0, 32'hFFFFFFEF);
        do_op(0, 2'd0, 0, 32'h83, 32'h0, 0);
        lit("lb_zero", 0, 32'h000000EF);
        do_op(0, 2'd1, 1, 32'h82, 32'h0, 0);
        lit("lh_sign", 0, 32'hFFFFBEEF);
        do_op(0, 2'd1, 0, 32'h80, 32'h0, 0);
        lit("lh_zero", 0, 32'h0000DEAD);
        do_op(0, 2'd1, 1, 32'h81, 32'h0, 0);
        lit("misalign_rdata", 0, 32'h0000DEAD);
        do_op(1, 2'd2, 0, 32'h100, 32'h12345678, 0);
        lit("range_rdata", 0, 32'h0000DEAD);
        do_op(1, 2'd0, 0, 32'h81, 32'hFFFFFF5A, 0);
        lit("sb_mem", 1, 32'hDE5ABEEF);
        do_op(1, 2'd0, 0, 32'h81, 32'h00000077, 2);
        lit("rst_abort_mem", 1, 32'hDE5ABEEF);
        lit("rst_abort_rdata", 0, 32'h0);

        for (int i = 0; i < 300; i++)
            do_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 255)), $urandom, 0);

        repeat (3) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
